// File: rtl/jtag_tap_responder.sv
// IEEE 1149.1 TAP controller: the target end of the JTAG link.
// Decodes the 16 TAP states, holds the 4-bit instruction register and the
// IDCODE / BYPASS data registers, and hands shift/capture/update strobes and
// a select line to the debug unit.
//
// Optional feature: define JTAG_TAP_USERCODE_EN to build a 32-bit USERCODE DR
// selected by instruction 4'h3. Without it 4'h3 behaves as BYPASS.
//
// Ports:
//   tck_pad_i          JTAG clock (rising edge: FSM/shift, falling edge: TDO)
//   rst_pad_i          asynchronous active-high reset
//   tms_pad_i          test mode select
//   tdi_pad_i          test data in
//   tdo_pad_o          test data out (falling-edge registered)
//   tdo_oe_o           TDO enable, high in Shift-IR/Shift-DR
//   debug_select_o     active IR is DEBUG (4'h8)
//   shift_dr_o         FSM in Shift-DR
//   capture_dr_o       FSM in Capture-DR
//   update_dr_o        FSM in Update-DR
//   pause_dr_o         FSM in Pause-DR
//   test_logic_reset_o FSM in Test-Logic-Reset
//   debug_tdi_o        TDI forwarded to the debug chain
//   debug_tdo_i        serial return from the debug chain
module jtag_tap_responder #(
    parameter logic [31:0] IDCODE_VALUE   = 32'h14951185,
    parameter int unsigned IR_LEN         = 4,
    parameter logic [31:0] USERCODE_VALUE = 32'h00000000
) (
    input  logic tck_pad_i,
    input  logic rst_pad_i,
    input  logic tms_pad_i,
    input  logic tdi_pad_i,
    output logic tdo_pad_o,
    output logic tdo_oe_o,
    output logic debug_select_o,
    output logic shift_dr_o,
    output logic capture_dr_o,
    output logic update_dr_o,
    output logic pause_dr_o,
    output logic test_logic_reset_o,
    output logic debug_tdi_o,
    input  logic debug_tdo_i
);

    localparam int unsigned DR_W = 32;

    localparam logic [IR_LEN-1:0] IR_IDCODE   = IR_LEN'(4'h2);
    localparam logic [IR_LEN-1:0] IR_DEBUG    = IR_LEN'(4'h8);
    localparam logic [IR_LEN-1:0] IR_CAPTURE  = IR_LEN'(4'b0101);
`ifdef JTAG_TAP_USERCODE_EN
    localparam logic [IR_LEN-1:0] IR_USERCODE = IR_LEN'(4'h3);
`endif

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } tap_state_t;

    tap_state_t state, state_next;

    logic [IR_LEN-1:0] ir_shift;
    logic [IR_LEN-1:0] ir;
    logic              bypass_reg;
    logic [DR_W-1:0]   idcode_sr;
    logic              dr_tdo;
`ifdef JTAG_TAP_USERCODE_EN
    logic [DR_W-1:0]   usercode_sr;
`else
    logic              unused_usercode;
    assign unused_usercode = ^USERCODE_VALUE;
`endif

    // TAP state register
    always_ff @(posedge tck_pad_i or posedge rst_pad_i) begin
        if (rst_pad_i) state <= TLR;
        else           state <= state_next;
    end

    // Next-state decode and state strobes
    always_comb begin
        state_next         = state;
        shift_dr_o         = 1'b0;
        capture_dr_o       = 1'b0;
        update_dr_o        = 1'b0;
        pause_dr_o         = 1'b0;
        test_logic_reset_o = 1'b0;
        case (state)
            TLR:      state_next = tms_pad_i ? TLR    : RTI;
            RTI:      state_next = tms_pad_i ? SEL_DR : RTI;
            SEL_DR:   state_next = tms_pad_i ? SEL_IR : CAP_DR;
            CAP_DR:   state_next = tms_pad_i ? EX1_DR : SH_DR;
            SH_DR:    state_next = tms_pad_i ? EX1_DR : SH_DR;
            EX1_DR:   state_next = tms_pad_i ? UPD_DR : PAUSE_DR;
            PAUSE_DR: state_next = tms_pad_i ? EX2_DR : PAUSE_DR;
            EX2_DR:   state_next = tms_pad_i ? UPD_DR : SH_DR;
            UPD_DR:   state_next = tms_pad_i ? SEL_DR : RTI;
            SEL_IR:   state_next = tms_pad_i ? TLR    : CAP_IR;
            CAP_IR:   state_next = tms_pad_i ? EX1_IR : SH_IR;
            SH_IR:    state_next = tms_pad_i ? EX1_IR : SH_IR;
            EX1_IR:   state_next = tms_pad_i ? UPD_IR : PAUSE_IR;
            PAUSE_IR: state_next = tms_pad_i ? EX2_IR : PAUSE_IR;
            EX2_IR:   state_next = tms_pad_i ? UPD_IR : SH_IR;
            UPD_IR:   state_next = tms_pad_i ? SEL_DR : RTI;
            default:  state_next = TLR;
        endcase
        shift_dr_o         = (state == SH_DR);
        capture_dr_o       = (state == CAP_DR);
        update_dr_o        = (state == UPD_DR);
        pause_dr_o         = (state == PAUSE_DR);
        test_logic_reset_o = (state == TLR);
    end

    // Instruction and data registers; contents hold outside Capture/Shift
    always_ff @(posedge tck_pad_i or posedge rst_pad_i) begin
        if (rst_pad_i) begin
            ir_shift    <= '0;
            ir          <= IR_IDCODE;
            bypass_reg  <= 1'b0;
            idcode_sr   <= IDCODE_VALUE;
`ifdef JTAG_TAP_USERCODE_EN
            usercode_sr <= USERCODE_VALUE;
`endif
        end else begin
            if (state == CAP_IR)
                ir_shift <= IR_CAPTURE;
            else if (state == SH_IR)
                ir_shift <= {tdi_pad_i, ir_shift[IR_LEN-1:1]};

            // Any entry into TLR restores IDCODE as the active instruction
            if (state_next == TLR)
                ir <= IR_IDCODE;
            else if (state == UPD_IR)
                ir <= ir_shift;

            // Only the selected DR reaches TDO, so all of them capture/shift
            if (state == CAP_DR) begin
                bypass_reg  <= 1'b0;
                idcode_sr   <= IDCODE_VALUE;
`ifdef JTAG_TAP_USERCODE_EN
                usercode_sr <= USERCODE_VALUE;
`endif
            end else if (state == SH_DR) begin
                bypass_reg  <= tdi_pad_i;
                idcode_sr   <= {tdi_pad_i, idcode_sr[DR_W-1:1]};
`ifdef JTAG_TAP_USERCODE_EN
                usercode_sr <= {tdi_pad_i, usercode_sr[DR_W-1:1]};
`endif
            end
        end
    end

    // Serial output of the DR selected by the active instruction
    always_comb begin
        dr_tdo = bypass_reg;
        case (ir)
            IR_IDCODE:   dr_tdo = idcode_sr[0];
            IR_DEBUG:    dr_tdo = debug_tdo_i;
`ifdef JTAG_TAP_USERCODE_EN
            IR_USERCODE: dr_tdo = usercode_sr[0];
`endif
            default:     dr_tdo = bypass_reg;
        endcase
    end

    // TDO and its enable change on the falling edge
    always_ff @(negedge tck_pad_i or posedge rst_pad_i) begin
        if (rst_pad_i) begin
            tdo_pad_o <= 1'b0;
            tdo_oe_o  <= 1'b0;
        end else begin
            tdo_oe_o <= (state == SH_IR) || (state == SH_DR);
            case (state)
                SH_IR:   tdo_pad_o <= ir_shift[0];
                SH_DR:   tdo_pad_o <= dr_tdo;
                default: tdo_pad_o <= 1'b0;
            endcase
        end
    end

    assign debug_select_o = (ir == IR_DEBUG);
    assign debug_tdi_o    = tdi_pad_i;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder: drives TMS/TDI in the low phase of
// TCK and samples TDO just before each rising edge, as a JTAG host would.
module tb_jtag_tap_responder;

    localparam logic [31:0] IDCODE   = 32'h14951185;
    localparam logic [31:0] USERCODE = 32'hCAFEF00D;

    logic tck, rst, tms, tdi, dbg_tdo;
    logic tdo, tdo_oe, dbg_sel, sh_dr, cap_dr, upd_dr, pause_dr, tlr, dbg_tdi;

    int checks = 0;
    int errors = 0;

    bit cnt_en = 1'b0;
    int cap_cnt = 0;
    int upd_cnt = 0;
    int pause_cnt = 0;

    jtag_tap_responder #(
        .IDCODE_VALUE  (IDCODE),
        .IR_LEN        (4),
        .USERCODE_VALUE(USERCODE)
    ) dut (
        .tck_pad_i         (tck),
        .rst_pad_i         (rst),
        .tms_pad_i         (tms),
        .tdi_pad_i         (tdi),
        .tdo_pad_o         (tdo),
        .tdo_oe_o          (tdo_oe),
        .debug_select_o    (dbg_sel),
        .shift_dr_o        (sh_dr),
        .capture_dr_o      (cap_dr),
        .update_dr_o       (upd_dr),
        .pause_dr_o        (pause_dr),
        .test_logic_reset_o(tlr),
        .debug_tdi_o       (dbg_tdi),
        .debug_tdo_i       (dbg_tdo)
    );

    initial begin
        tck = 1'b0;
        forever #5 tck = ~tck;
    end

    // Count DR strobe visits; each TAP state lasts one full TCK cycle
    always @(posedge tck) begin
        if (cnt_en) begin
            if (cap_dr)   cap_cnt++;
            if (upd_dr)   upd_cnt++;
            if (pause_dr) pause_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One TCK cycle: sample TDO, apply TMS/TDI, pass both edges
    task automatic step(input logic m, input logic d, input logic dbg, output logic s);
        s       = tdo;
        tms     = m;
        tdi     = d;
        dbg_tdo = dbg;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    task automatic go(input logic m);
        logic s;
        step(m, 1'b0, 1'b0, s);
    endtask

    // RTI -> shift 4-bit IR -> RTI; returns captured IR bits
    task automatic shift_ir(input logic [3:0] v, output logic [3:0] cap);
        logic s;
        go(1'b1); go(1'b1); go(1'b0); go(1'b0);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, v[i], 1'b0, s);
            cap[i] = s;
        end
        go(1'b1); go(1'b0);
    endtask

    // RTI -> shift n DR bits LSB first -> RTI
    task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
        logic s;
        dout = '0;
        go(1'b1); go(1'b0); go(1'b0);
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, din[i], 1'b0, s);
            dout[i] = s;
        end
        go(1'b1); go(1'b0);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        #2;
        checks++;
        if (tlr !== 1'b1) begin errors++; $display("FAIL reset_tlr: got %b want 1", tlr); end
        checks++;
        if ({tdo, tdo_oe, dbg_sel, sh_dr, cap_dr, upd_dr, pause_dr} !== 7'b0) begin
            errors++; $display("FAIL reset_outputs: got %b want 0000000",
                {tdo, tdo_oe, dbg_sel, sh_dr, cap_dr, upd_dr, pause_dr});
        end
        @(negedge tck); #1;
        rst = 1'b0;
        go(1'b0);                                  // RTI
        go(1'b1); go(1'b0); go(1'b0);              // ShDR
        for (int i = 0; i < 5; i++) go(1'b0);
        checks++;
        if (tdo_oe !== 1'b1 || sh_dr !== 1'b1) begin
            errors++; $display("FAIL shift_oe: got oe=%b sh=%b want 1 1", tdo_oe, sh_dr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({tlr, tdo, tdo_oe, sh_dr} !== 4'b1000) begin
            errors++; $display("FAIL midshift_reset: got %b want 1000", {tlr, tdo, tdo_oe, sh_dr});
        end
        #1;
        rst = 1'b0;
        go(1'b0);                                  // RTI, IR still IDCODE
        shift_dr(32, 32'h0, d);
        checks++;
        if (d !== IDCODE) begin errors++; $display("FAIL idcode_after_reset: got %h want %h", d, IDCODE); end
    endtask

    task automatic test_bypass;
        logic [3:0]  c;
        logic [31:0] d;
        shift_ir(4'hF, c);
        checks++;
        if (c !== 4'b0101) begin errors++; $display("FAIL ir_capture_f: got %b want 0101", c); end
        shift_dr(8, 32'hB2, d);
        checks++;
        if (d[7:0] !== 8'h64) begin errors++; $display("FAIL bypass_delay: got %h want 64", d[7:0]); end
    endtask

    task automatic test_debug;
        logic [3:0] c;
        logic [8:0] dv;
        logic [7:0] got;
        logic       s;
        dv = 9'h16D;
        shift_ir(4'h8, c);
        checks++;
        if (c !== 4'b0101) begin errors++; $display("FAIL ir_capture_8: got %b want 0101", c); end
        checks++;
        if (dbg_sel !== 1'b1) begin errors++; $display("FAIL debug_select: got %b want 1", dbg_sel); end
        go(1'b1); go(1'b0);                        // CapDR
        checks++;
        if (cap_dr !== 1'b1) begin errors++; $display("FAIL capture_strobe: got %b want 1", cap_dr); end
        step(1'b0, 1'b1, dv[0], s);                // ShDR
        checks++;
        if (dbg_tdi !== 1'b1 || sh_dr !== 1'b1) begin
            errors++; $display("FAIL debug_tdi_shift: got tdi=%b sh=%b want 1 1", dbg_tdi, sh_dr);
        end
        for (int k = 0; k < 8; k++) begin
            step(k == 7, 1'b0, dv[k+1], s);
            got[k] = s;
        end
        checks++;
        if (got !== dv[7:0]) begin errors++; $display("FAIL debug_tdo_mirror: got %h want %h", got, dv[7:0]); end
        go(1'b0);                                  // PauseDR
        checks++;
        if (pause_dr !== 1'b1) begin errors++; $display("FAIL pause_strobe: got %b want 1", pause_dr); end
    endtask

    task automatic test_tlr_from_pause;
        logic [31:0] d;
        for (int i = 0; i < 5; i++) go(1'b1);
        checks++;
        if (tlr !== 1'b1 || dbg_sel !== 1'b0) begin
            errors++; $display("FAIL tms5_tlr: got tlr=%b sel=%b want 1 0", tlr, dbg_sel);
        end
        go(1'b0);
        shift_dr(32, 32'h0, d);
        checks++;
        if (d !== IDCODE) begin errors++; $display("FAIL idcode_after_tlr: got %h want %h", d, IDCODE); end
    endtask

    task automatic test_usercode;
        logic [3:0]  c;
        logic [31:0] d;
        logic [31:0] din;
        din = 32'hA5A50F0F;
        shift_ir(4'h3, c);
        shift_dr(32, din, d);
        checks++;
`ifdef JTAG_TAP_USERCODE_EN
        if (d !== USERCODE) begin errors++; $display("FAIL usercode: got %h want %h", d, USERCODE); end
`else
        if (d !== {din[30:0], 1'b0}) begin
            errors++; $display("FAIL usercode_bypass: got %h want %h", d, {din[30:0], 1'b0});
        end
`endif
    endtask

    task automatic test_pause_split;
        logic [3:0]  c;
        logic [31:0] d;
        logic        s;
        shift_ir(4'h2, c);
        cap_cnt = 0; upd_cnt = 0; pause_cnt = 0;
        cnt_en = 1'b1;
        d = '0;
        go(1'b1); go(1'b0); go(1'b0);              // ShDR
        for (int i = 0; i < 12; i++) begin
            step(i == 11, 1'b0, 1'b0, s);
            d[i] = s;
        end
        go(1'b0); go(1'b0);                        // PauseDR, held
        go(1'b1); go(1'b0);                        // Ex2DR -> ShDR
        for (int i = 12; i < 32; i++) begin
            step(i == 31, 1'b0, 1'b0, s);
            d[i] = s;
        end
        go(1'b1); go(1'b0);                        // UpdDR -> RTI
        cnt_en = 1'b0;
        checks++;
        if (d !== IDCODE) begin errors++; $display("FAIL pause_split_data: got %h want %h", d, IDCODE); end
        checks++;
        if (cap_cnt != 1 || upd_cnt != 1) begin
            errors++; $display("FAIL pause_split_strobes: got cap=%0d upd=%0d want 1 1", cap_cnt, upd_cnt);
        end
        checks++;
        if (pause_cnt != 2) begin errors++; $display("FAIL pause_split_pause: got %0d want 2", pause_cnt); end
    endtask

    initial begin
        rst = 1'b1; tms = 1'b1; tdi = 1'b0; dbg_tdo = 1'b0;
        test_reset();
        test_bypass();
        test_debug();
        test_tlr_from_pause();
        test_usercode();
        test_pause_split();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_tap_responder.md
Name: jtag_tap_responder

Overview:
- IEEE 1149.1 TAP controller; the target end of the JTAG link that the jtag_vpi bench driver initiates.
- Sits between the tms/tck/tdi/tdo pads and the debug-interface chain inside orpsoc_top.
- Decodes TAP states, holds the instruction register and the IDCODE and BYPASS data registers.
- Exposes shift/capture/update strobes and a select line to the debug unit.

Parameters:
- IDCODE_VALUE, 32'h14951185, value captured into the IDCODE DR; bit 0 must be 1.
- IR_LEN, 4, instruction register width (fixed at 4; other values unsupported).
- USERCODE_VALUE, 32'h00000000, value of the USERCODE DR (only with the optional feature).

Ports:
- tck_pad_i  in  1  JTAG clock; the single clock of the block; both edges used.
- rst_pad_i  in  1  asynchronous active-high reset.
- tms_pad_i  in  1  test mode select; sampled on tck rising edge.
- tdi_pad_i  in  1  test data in; sampled on tck rising edge.
- tdo_pad_o  out 1  test data out; updated on tck falling edge.
- tdo_oe_o   out 1  high while in Shift-IR or Shift-DR (falling-edge registered).
- debug_select_o  out 1  IR == DEBUG (4'h8).
- shift_dr_o  out 1  FSM in Shift-DR.
- capture_dr_o  out 1  FSM in Capture-DR.
- update_dr_o  out 1  FSM in Update-DR.
- pause_dr_o  out 1  FSM in Pause-DR.
- test_logic_reset_o  out 1  FSM in Test-Logic-Reset.
- debug_tdi_o  out 1  tdi_pad_i passed through to the debug chain.
- debug_tdo_i  in  1  serial output of the debug chain; used when DEBUG is selected.

Behaviour:
- Reset: rst_pad_i high asynchronously forces:
  - FSM = Test-Logic-Reset, IR = IDCODE (4'h2), BYPASS reg = 0, IDCODE shift reg = IDCODE_VALUE;
  - tdo_pad_o = 0, tdo_oe_o = 0, test_logic_reset_o = 1, all other strobes and debug_select_o = 0.
- Reset may assert mid-shift; all partial shift data is discarded.
- FSM: 16 standard states, transitions on tck rising edge per tms_pad_i:
  - TLR: tms0 -> RTI. RTI: tms1 -> SelDR.
  - SelDR: 0 -> CapDR, 1 -> SelIR. CapDR: 0 -> ShDR, 1 -> Ex1DR.
  - ShDR: 1 -> Ex1DR. Ex1DR: 0 -> PauseDR, 1 -> UpdDR.
  - PauseDR: 1 -> Ex2DR. Ex2DR: 0 -> ShDR, 1 -> UpdDR.
  - UpdDR: 0 -> RTI, 1 -> SelDR.
  - SelIR: 0 -> CapIR, 1 -> TLR. The IR branch mirrors the DR branch.
  - Any state with tms held 1 for 5 consecutive rising edges reaches TLR.
- Entering TLR by any path reloads IR = IDCODE.
- IR:
  - CapIR loads the shift register with 4'b0101 (LSBs 01 per 1149.1).
  - ShIR shifts right: tdi enters the MSB, the LSB goes to tdo.
  - UpdIR copies the shift register to the active IR.
  - Active IR is unchanged until UpdIR.
- Instruction decode:
  - 4'h2 IDCODE; 4'h8 DEBUG; 4'hF BYPASS.
  - 4'h3 USERCODE when the feature is enabled.
  - Every other code behaves as BYPASS.
- IDCODE DR: CapDR loads IDCODE_VALUE; ShDR shifts right with tdi into bit 31, LSB first out.
- BYPASS DR: CapDR loads 0; ShDR loads tdi, giving one cycle of delay.
- DEBUG: tdo source is debug_tdo_i; the strobes are valid and the debug chain owns the data.
- Strobes (shift/capture/update/pause/test_logic_reset) decode the current state combinationally and are asserted for every instruction. The debug unit qualifies them with debug_select_o.
- TDO:
  - On the tck falling edge, tdo_pad_o is loaded with:
    - the IR shift LSB in ShIR;
    - the selected DR output in ShDR;
    - otherwise 0.
  - Shift latency: the first captured bit appears on tdo during the falling edge after entry to Shift.
- Outside Shift, the IR and DR shift registers hold their value (Pause preserves contents).

Optional Feature:
- Macro: JTAG_TAP_USERCODE_EN.
- Defined: instruction 4'h3 selects a 32-bit USERCODE DR. CapDR loads USERCODE_VALUE; shifting is identical to IDCODE.
- Undefined: 4'h3 decodes as BYPASS and the USERCODE register is not built.

Test Plan:
- Assert rst_pad_i mid-ShDR, release, then ShDR 32 bits with no IR load -> tdo yields 32'h14951185 LSB first; test_logic_reset_o = 1 after reset.
- From RTI, shift IR 4'hF, then ShDR with tdi = 8'b10110010 -> tdo returns the same pattern delayed 1 bit, first bit 0.
- Shift IR with tdi = 4'h8 -> captured bits out = 0101 (LSB first 1,0,1,0); after UpdIR debug_select_o = 1; ShDR tdo mirrors debug_tdo_i.
- Hold tms = 1 for 5 edges from PauseDR -> FSM in TLR, IR = 4'h2, debug_select_o = 0.
- IR = 4'h3: with JTAG_TAP_USERCODE_EN and USERCODE_VALUE = 32'hCAFEF00D -> ShDR returns 32'hCAFEF00D; without the macro -> single-bit bypass, captured 0.
- IDCODE shift split by PauseDR after 12 bits, resume via Ex2DR -> remaining 20 bits continue exactly; strobes capture/update pulse once each.
